// File: rtl/conv2d_stream_if.sv
// Pixel-in / result-out valid-ready stream bundle for conv2d_stream.
interface conv2d_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16
);
  logic signed [DATA_WIDTH-1:0] pixel_in;
  logic                         pixel_valid;
  logic                         pixel_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_sat;

  modport master (
    output pixel_in, pixel_valid, out_ready,
    input  pixel_ready, out_data, out_valid, out_sat
  );

  modport slave (
    input  pixel_in, pixel_valid, out_ready,
    output pixel_ready, out_data, out_valid, out_sat
  );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution over raster-order frames with line buffers,
// runtime frame size, arithmetic output shift and signed saturation.
module conv2d_stream #(
  parameter int K          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_W      = 64,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_W+1)-1:0]     img_w,
  input  logic [15:0]                    img_h,
  input  logic [4:0]                     shift,
  input  logic signed [DATA_WIDTH-1:0]   kernel_in,
  input  logic [$clog2(K*K)-1:0]         kernel_addr,
  input  logic                           kernel_wen,
  conv2d_stream_if.slave                 io,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(K*K);
  localparam int KK        = K*K;
  localparam int WW        = $clog2(MAX_W+1);
  localparam int AW        = $clog2(K*K);
  localparam int IW        = $clog2(MAX_W);
  localparam int EXT_W     = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;

  localparam logic [WW-1:0] K_W    = WW'(K);
  localparam logic [WW-1:0] KM1_W  = WW'(K-1);
  localparam logic [WW-1:0] MAXW_W = WW'(MAX_W);
  localparam logic [15:0]   K_H    = 16'(K);
  localparam logic [15:0]   KM1_H  = 16'(K-1);
  localparam logic [AW-1:0] KK_A   = AW'(KK);

  localparam logic signed [EXT_W-1:0] OMAX = EXT_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] OMIN = ~OMAX;

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  pix_t                        kern_q [KK];
  pix_t                        kern_d [KK];
  pix_t                        lb_q   [K-1][MAX_W];
  pix_t                        lb_d   [K-1][MAX_W];
  pix_t                        win_q  [K][K];
  pix_t                        win_d  [K][K];
  logic [WW-1:0]               col_q, col_d;
  logic [15:0]                 row_q, row_d;
  logic [WW-1:0]               w_q, w_d;
  logic [15:0]                 h_q, h_d;
  logic [4:0]                  shift_q, shift_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_sat_q, out_sat_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        cfg_err_q, cfg_err_d;

  pix_t                        col_vec [K];
  pix_t                        win_sh  [K][K];
  logic [IW-1:0]               col_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sh;
  logic signed [EXT_W-1:0]     acc_ext;
  logic signed [OUT_WIDTH-1:0] res;
  logic                        res_sat;
  logic                        pix_rdy;
  logic                        accept;
  logic                        win_ok;
  logic                        last_pix;
  logic                        cfg_ok;

  always_comb begin
    state_d     = state_q;
    kern_d      = kern_q;
    lb_d        = lb_q;
    win_d       = win_q;
    col_d       = col_q;
    row_d       = row_q;
    w_d         = w_q;
    h_d         = h_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    cfg_err_d   = 1'b0;
    prod        = '0;
    acc         = '0;

    col_idx = col_q[IW-1:0];
    for (int unsigned i = 0; i < K-1; i++) begin
      col_vec[i] = lb_q[i][col_idx];
    end
    col_vec[K-1] = io.pixel_in;

    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K-1; j++) begin
        win_sh[i][j] = win_q[i][j+1];
      end
      win_sh[i][K-1] = col_vec[i];
    end

    // MAC over the window as it will look after the incoming column shifts in
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        prod = kern_q[i*K+j] * win_sh[i][j];
        acc  = acc + ACC_WIDTH'(prod);
      end
    end
    acc_sh  = acc >>> shift_q;
    acc_ext = EXT_W'(acc_sh);
    if (acc_ext > OMAX) begin
      res     = OMAX[OUT_WIDTH-1:0];
      res_sat = 1'b1;
    end else if (acc_ext < OMIN) begin
      res     = OMIN[OUT_WIDTH-1:0];
      res_sat = 1'b1;
    end else begin
      res     = OUT_WIDTH'(acc_ext);
      res_sat = 1'b0;
    end

    pix_rdy  = (state_q == S_RUN) && (!out_valid_q || io.out_ready);
    accept   = pix_rdy && io.pixel_valid;
    win_ok   = (row_q >= KM1_H) && (col_q >= KM1_W);
    last_pix = (row_q == h_q - 16'd1) && (col_q == w_q - WW'(1));
    cfg_ok   = (img_w >= K_W) && (img_w <= MAXW_W) && (img_h >= K_H);

    if (io.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      win_d = win_sh;
      // Rows age by one slot per column; equivalent to rotating a line pointer
      for (int unsigned i = 0; i < K-2; i++) begin
        lb_d[i][col_idx] = lb_q[i+1][col_idx];
      end
      lb_d[K-2][col_idx] = io.pixel_in;
      if (col_q == w_q - WW'(1)) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + WW'(1);
      end
      if (win_ok) begin
        out_data_d  = res;
        out_sat_d   = res_sat;
        out_valid_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (kernel_wen && (kernel_addr < KK_A)) begin
          kern_d[kernel_addr] = kernel_in;
        end
        if (start) begin
          if (cfg_ok) begin
            state_d = S_RUN;
            w_d     = img_w;
            h_d     = img_h;
            shift_d = shift;
            col_d   = '0;
            row_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept && last_pix) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!out_valid_q || io.out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < KK; i++) begin
        kern_q[i] <= (i == KK/2) ? pix_t'(1) : '0;
      end
      for (int unsigned i = 0; i < K-1; i++) begin
        for (int unsigned j = 0; j < MAX_W; j++) begin
          lb_q[i][j] <= '0;
        end
      end
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
      col_q       <= '0;
      row_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kern_q      <= kern_d;
      lb_q        <= lb_d;
      win_q       <= win_d;
      col_q       <= col_d;
      row_q       <= row_d;
      w_q         <= w_d;
      h_q         <= h_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign io.pixel_ready = pix_rdy;
  assign io.out_data    = out_data_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_sat     = out_sat_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;

endmodule
